// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared definitions for the 8-bit computer: sequencer state
//               encoding, opcode constants and the instruction-length /
//               execute-step tables used by both sequencer and datapath decode.
// Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

    // Sequencer states; explicit 3-bit encoding.
    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_OPND1 = 3'd1,
        ST_OPND2 = 3'd2,
        ST_EXEC  = 3'd3,
        ST_HALT  = 3'd4
    } seq_state_e;

    // Opcode map.
    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_MOVI  = 8'h01;
    localparam logic [7:0] OP_MOV   = 8'h02;
    localparam logic [7:0] OP_ADD   = 8'h03;
    localparam logic [7:0] OP_SUB   = 8'h04;
    localparam logic [7:0] OP_AND   = 8'h05;
    localparam logic [7:0] OP_OR    = 8'h06;
    localparam logic [7:0] OP_XOR   = 8'h07;
    localparam logic [7:0] OP_NOT   = 8'h08;
    localparam logic [7:0] OP_CMPEQ = 8'h09;
    localparam logic [7:0] OP_CMPLT = 8'h0a;
    localparam logic [7:0] OP_CMPGT = 8'h0b;
    localparam logic [7:0] OP_PUSH  = 8'h0c;
    localparam logic [7:0] OP_POP   = 8'h0d;
    localparam logic [7:0] OP_JMP   = 8'h0e;
    localparam logic [7:0] OP_JZ    = 8'h0f;
    localparam logic [7:0] OP_OUT   = 8'h10;
    localparam logic [7:0] OP_HALT  = 8'hff;

    // True for the regular (non-halt) opcodes 00..10.
    function automatic logic op_is_defined(input logic [7:0] op);
        return (op <= OP_OUT);
    endfunction

    // Total instruction length in bytes, opcode included.
    function automatic logic [1:0] op_bytes(input logic [7:0] op);
        logic [1:0] n;
        if (op == OP_PUSH || op == OP_POP || op == OP_OUT) begin
            n = 2'd2;
        end else if (op >= OP_MOVI && op <= OP_JZ) begin
            n = 2'd3;
        end else begin
            n = 2'd1;
        end
        return n;
    endfunction

    // Number of execute steps; only the ALU group needs more than one.
    function automatic logic [1:0] op_steps(input logic [7:0] op);
        logic [1:0] n;
        if (op >= OP_ADD && op <= OP_NOT) begin
            n = 2'd3;
        end else begin
            n = 2'd1;
        end
        return n;
    endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/opcode_decoder.sv
`default_nettype none
// ============================================================================
// Module      : opcode_decoder
// Description : Combinational opcode classifier: instruction length, number
//               of execute steps, halt detection and undefined-opcode flag.
// Revision    : 1.0  initial release
// ============================================================================
module opcode_decoder
    import cpu_pkg::*;
#(
    parameter logic [7:0] HALT_OPCODE = 8'hff
) (
    input  logic [7:0] op,
    output logic [1:0] num_bytes,
    output logic [1:0] num_steps,
    output logic       is_halt,
    output logic       illegal
);

    // Table lookup; undefined opcodes degrade to a one-byte, one-step NOP.
    always_comb begin
        is_halt   = (op == HALT_OPCODE);
        illegal   = 1'b0;
        num_bytes = op_bytes(op);
        num_steps = op_steps(op);
        if (is_halt) begin
            num_bytes = 2'd1;
            num_steps = 2'd1;
        end else if (!op_is_defined(op)) begin
            illegal   = 1'b1;
            num_bytes = 2'd1;
            num_steps = 2'd1;
        end
    end

endmodule : opcode_decoder
`default_nettype wire

// File: rtl/instruction_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instruction_sequencer
// Description : Fetch/decode/execute controller. Owns the code pointer, reads
//               opcode and operand bytes over a valid handshake, then steps an
//               execute counter while holding the instruction stable.
// Revision    : 1.0  initial release
// ============================================================================
module instruction_sequencer
    import cpu_pkg::*;
#(
    parameter logic [7:0] RESET_PC    = 8'h00,
    parameter logic [7:0] HALT_OPCODE = 8'hff
) (
    input  logic       clk,
    input  logic       reset,       // asynchronous, active-low
    output logic [7:0] code_addr,
    output logic       code_req,
    input  logic       code_valid,
    input  logic [7:0] code_data,
    input  logic       stall,
    output logic [7:0] opcode,
    output logic [7:0] operand1,
    output logic [7:0] operand2,
    output logic       exec_valid,
    output logic [1:0] exec_step,
    output logic       instr_done,
    output logic       halted,
    output logic       illegal
);

    seq_state_e state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] opcode_q, opcode_d;
    logic [7:0] operand1_q, operand1_d;
    logic [7:0] operand2_q, operand2_d;
    logic [1:0] exec_step_q, exec_step_d;

    logic [7:0] dec_op;
    logic [1:0] dec_bytes;
    logic [1:0] dec_steps;
    logic       dec_halt;
    logic       dec_illegal;
    logic       accept;
    logic       last_step;

    // In FETCH the byte on the bus is classified; afterwards the latched opcode.
    assign dec_op = (state_q == ST_FETCH) ? code_data : opcode_q;

    opcode_decoder #(
        .HALT_OPCODE (HALT_OPCODE)
    ) u_decoder (
        .op        (dec_op),
        .num_bytes (dec_bytes),
        .num_steps (dec_steps),
        .is_halt   (dec_halt),
        .illegal   (dec_illegal)
    );

    assign code_req   = (state_q == ST_FETCH) || (state_q == ST_OPND1) || (state_q == ST_OPND2);
    assign accept     = code_req & code_valid;
    assign exec_valid = (state_q == ST_EXEC);
    assign halted     = (state_q == ST_HALT);
    assign last_step  = (exec_step_q == (dec_steps - 2'd1));
    assign instr_done = exec_valid & ~stall & last_step;
    // Gated by reset so a valid byte sitting on the bus during reset never flags.
    assign illegal    = reset & (state_q == ST_FETCH) & code_valid & dec_illegal;

    assign code_addr  = pc_q;
    assign opcode     = opcode_q;
    assign operand1   = operand1_q;
    assign operand2   = operand2_q;
    assign exec_step  = exec_step_q;

    // Next-state, pointer and latch computation.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        opcode_d    = opcode_q;
        operand1_d  = operand1_q;
        operand2_d  = operand2_q;
        exec_step_d = exec_step_q;

        // Every accepted byte advances the pointer; 8'hff wraps to 8'h00.
        if (accept) begin
            pc_d = pc_q + 8'd1;
        end

        unique case (state_q)
            ST_FETCH: begin
                if (code_valid) begin
                    opcode_d   = code_data;
                    operand1_d = 8'h00;
                    operand2_d = 8'h00;
                    if (dec_halt) begin
                        state_d = ST_HALT;
                    end else if (dec_bytes == 2'd1) begin
                        state_d = ST_EXEC;
                    end else begin
                        state_d = ST_OPND1;
                    end
                end
            end
            ST_OPND1: begin
                if (code_valid) begin
                    operand1_d = code_data;
                    state_d    = (dec_bytes == 2'd2) ? ST_EXEC : ST_OPND2;
                end
            end
            ST_OPND2: begin
                if (code_valid) begin
                    operand2_d = code_data;
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!stall) begin
                    if (last_step) begin
                        exec_step_d = 2'd0;
                        state_d     = ST_FETCH;
                    end else begin
                        exec_step_d = exec_step_q + 2'd1;
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d     = ST_FETCH;
                exec_step_d = 2'd0;
            end
        endcase
    end

    // State and data registers; reset aborts any partially fetched instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_FETCH;
            pc_q        <= RESET_PC;
            opcode_q    <= 8'h00;
            operand1_q  <= 8'h00;
            operand2_q  <= 8'h00;
            exec_step_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            opcode_q    <= opcode_d;
            operand1_q  <= operand1_d;
            operand2_q  <= operand2_d;
            exec_step_q <= exec_step_d;
        end
    end

endmodule : instruction_sequencer
`default_nettype wire

// File: tb/tb_instruction_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_sequencer
// Description : Self-checking bench for instruction_sequencer: directed
//               scenarios plus a random program checked against an
//               instruction-level reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_instruction_sequencer;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DUT0: default reset pointer.
    logic       reset0, code_valid0, stall0;
    logic [7:0] code_addr0, code_data0, opcode0, operand1_0, operand2_0;
    logic       code_req0, exec_valid0, instr_done0, halted0, illegal0;
    logic [1:0] exec_step0;
    logic [7:0] mem0 [256];
    assign code_data0 = mem0[code_addr0];

    // DUT1: reset pointer near the top of the address space.
    logic       reset1, code_valid1, stall1;
    logic [7:0] code_addr1, code_data1, opcode1, operand1_1, operand2_1;
    logic       code_req1, exec_valid1, instr_done1, halted1, illegal1;
    logic [1:0] exec_step1;
    logic [7:0] mem1 [256];
    assign code_data1 = mem1[code_addr1];

    instruction_sequencer #(.RESET_PC(8'h00), .HALT_OPCODE(8'hff)) u_dut0 (
        .clk(clk), .reset(reset0), .code_addr(code_addr0), .code_req(code_req0),
        .code_valid(code_valid0), .code_data(code_data0), .stall(stall0),
        .opcode(opcode0), .operand1(operand1_0), .operand2(operand2_0),
        .exec_valid(exec_valid0), .exec_step(exec_step0), .instr_done(instr_done0),
        .halted(halted0), .illegal(illegal0)
    );

    instruction_sequencer #(.RESET_PC(8'hfe), .HALT_OPCODE(8'hff)) u_dut1 (
        .clk(clk), .reset(reset1), .code_addr(code_addr1), .code_req(code_req1),
        .code_valid(code_valid1), .code_data(code_data1), .stall(stall1),
        .opcode(opcode1), .operand1(operand1_1), .operand2(operand2_1),
        .exec_valid(exec_valid1), .exec_step(exec_step1), .instr_done(instr_done1),
        .halted(halted1), .illegal(illegal1)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Instruction table as opcode ranges: length in bytes, execute steps.
    int rng_lo  [8] = '{'h00, 'h01, 'h03, 'h09, 'h0c, 'h0e, 'h10, 'hff};
    int rng_hi  [8] = '{'h00, 'h02, 'h08, 'h0b, 'h0d, 'h0f, 'h10, 'hff};
    int rng_len [8] = '{1, 3, 3, 3, 2, 3, 2, 1};
    int rng_stp [8] = '{1, 1, 3, 1, 1, 1, 1, 1};

    function automatic void ref_lookup(input int op, output int len, output int stp, output bit legal);
        len = 1; stp = 1; legal = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (op >= rng_lo[i] && op <= rng_hi[i]) begin
                len = rng_len[i]; stp = rng_stp[i]; legal = 1'b1;
            end
        end
    endfunction

    // Expected instruction stream for the random program.
    int exp_op[$], exp_o1[$], exp_o2[$], exp_stp[$], exp_end[$];

    initial begin
        int pc_m;
        int n_illegal;
        int idx;
        int unstalled;
        int illegal_seen;

        reset0 = 1'b0; reset1 = 1'b0;
        code_valid0 = 1'b1; stall0 = 1'b0;
        code_valid1 = 1'b1; stall1 = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem0[i] = 8'h00;
            mem1[i] = 8'h00;
        end
        mem0[0] = 8'h01; mem0[1] = 8'h02; mem0[2] = 8'h2a; mem0[3] = 8'h00;
        mem0[4] = 8'h03; mem0[5] = 8'h00; mem0[6] = 8'h01;
        mem1[8'hfe] = 8'h01; mem1[8'hff] = 8'h11; mem1[8'h00] = 8'h22; mem1[8'h01] = 8'h00;

        // ---------------- reset state ----------------
        tick(); tick();
        #1;
        chk("rst_code_req",   32'(code_req0),   32'h1);
        chk("rst_code_addr",  32'(code_addr0),  32'h00);
        chk("rst_exec_valid", 32'(exec_valid0), 32'h0);
        chk("rst_instr_done", 32'(instr_done0), 32'h0);
        chk("rst_halted",     32'(halted0),     32'h0);
        chk("rst_illegal",    32'(illegal0),    32'h0);
        chk("rst_opcode",     32'(opcode0),     32'h00);
        chk("rst_operand2",   32'(operand2_0),  32'h00);
        chk("rst_exec_step",  32'(exec_step0),  32'h0);
        chk("rst1_code_addr", 32'(code_addr1),  32'hfe);
        reset0 = 1'b1;

        // ---------------- 3-byte MOVI then NOP, no wait states ----------------
        tick();
        chk("t1_addr_e1",   32'(code_addr0), 32'h01);
        chk("t1_opcode_e1", 32'(opcode0),    32'h01);
        tick(); tick();
        chk("t1_exec_valid", 32'(exec_valid0), 32'h1);
        chk("t1_operand1",   32'(operand1_0),  32'h02);
        chk("t1_operand2",   32'(operand2_0),  32'h2a);
        chk("t1_instr_done", 32'(instr_done0), 32'h1);
        tick();
        chk("t1_fetch_req",  32'(code_req0),   32'h1);
        chk("t1_exec_off",   32'(exec_valid0), 32'h0);
        chk("t1_opc_stable", 32'(opcode0),     32'h01);
        chk("t1_addr_e4",    32'(code_addr0),  32'h03);
        tick();
        chk("t1_nop_opcode", 32'(opcode0),     32'h00);
        chk("t1_nop_op1",    32'(operand1_0),  32'h00);
        chk("t1_nop_done",   32'(instr_done0), 32'h1);
        tick();
        chk("t1_pc_final",   32'(code_addr0),  32'h04);

        // ---------------- ALU op with stall at step 1 ----------------
        tick(); tick(); tick();
        chk("t2_opcode",  32'(opcode0),     32'h03);
        chk("t2_step0",   32'(exec_step0),  32'h0);
        chk("t2_done0",   32'(instr_done0), 32'h0);
        tick();
        chk("t2_step1a", 32'(exec_step0), 32'h1);
        stall0 = 1'b1;
        #1 chk("t2_done_stall_a", 32'(instr_done0), 32'h0);
        tick();
        chk("t2_step1b", 32'(exec_step0), 32'h1);
        chk("t2_done_stall_b", 32'(instr_done0), 32'h0);
        tick();
        chk("t2_step1c", 32'(exec_step0), 32'h1);
        stall0 = 1'b0;
        #1 chk("t2_done_step1", 32'(instr_done0), 32'h0);
        tick();
        chk("t2_step2", 32'(exec_step0),  32'h2);
        chk("t2_done",  32'(instr_done0), 32'h1);
        tick();
        chk("t2_exec_off", 32'(exec_valid0), 32'h0);
        chk("t2_pc",       32'(code_addr0),  32'h07);

        // ---------------- mid-operation reset, then wait states on operand ----------------
        reset0 = 1'b0;
        #1;
        chk("t3_rst_addr",   32'(code_addr0), 32'h00);
        chk("t3_rst_opcode", 32'(opcode0),    32'h00);
        mem0[0] = 8'h0c; mem0[1] = 8'h55; mem0[2] = 8'h00;
        tick();
        reset0 = 1'b1;
        tick();
        chk("t3_opcode", 32'(opcode0),    32'h0c);
        code_valid0 = 1'b0;
        for (int w = 0; w < 3; w++) begin
            tick();
            chk("t3_wait_req",  32'(code_req0),   32'h1);
            chk("t3_wait_exec", 32'(exec_valid0), 32'h0);
            chk("t3_wait_pc",   32'(code_addr0),  32'h01);
        end
        code_valid0 = 1'b1;
        tick();
        chk("t3_exec",     32'(exec_valid0), 32'h1);
        chk("t3_operand1", 32'(operand1_0),  32'h55);
        chk("t3_done",     32'(instr_done0), 32'h1);
        chk("t3_pc",       32'(code_addr0),  32'h02);

        // ---------------- undefined opcode ----------------
        reset0 = 1'b0;
        mem0[0] = 8'h5a; mem0[1] = 8'h00;
        tick();
        #1 chk("t4_illegal_in_reset", 32'(illegal0), 32'h0);
        reset0 = 1'b1;
        #1 chk("t4_illegal_pulse", 32'(illegal0), 32'h1);
        tick();
        chk("t4_illegal_clear", 32'(illegal0),    32'h0);
        chk("t4_exec",          32'(exec_valid0), 32'h1);
        chk("t4_opcode",        32'(opcode0),     32'h5a);
        chk("t4_done",          32'(instr_done0), 32'h1);
        tick();
        chk("t4_resume_pc", 32'(code_addr0),  32'h01);
        chk("t4_exec_off",  32'(exec_valid0), 32'h0);

        // ---------------- pointer wrap on DUT1 ----------------
        reset1 = 1'b1;
        tick();
        chk("t5_addr_ff", 32'(code_addr1), 32'hff);
        tick();
        chk("t5_addr_00", 32'(code_addr1), 32'h00);
        tick();
        chk("t5_exec",     32'(exec_valid1), 32'h1);
        chk("t5_operand1", 32'(operand1_1),  32'h11);
        chk("t5_operand2", 32'(operand2_1),  32'h22);
        chk("t5_addr_01",  32'(code_addr1),  32'h01);
        tick();
        chk("t5_fetch_addr", 32'(code_addr1), 32'h01);
        tick();
        chk("t5_next_opcode", 32'(opcode1), 32'h00);

        // ---------------- HALT and reset out of it ----------------
        reset0 = 1'b0;
        mem0[0] = 8'hff;
        tick();
        reset0 = 1'b1;
        tick();
        for (int h = 0; h < 20; h++) begin
            code_valid0 = 1'($urandom_range(0, 1));
            stall0      = 1'($urandom_range(0, 1));
            #1;
            chk("t6_halted",   32'(halted0),     32'h1);
            chk("t6_no_req",   32'(code_req0),   32'h0);
            chk("t6_no_exec",  32'(exec_valid0), 32'h0);
            tick();
        end
        #1 reset0 = 1'b0;
        #1;
        chk("t6_rst_halted", 32'(halted0),    32'h0);
        chk("t6_rst_addr",   32'(code_addr0), 32'h00);
        chk("t6_rst_req",    32'(code_req0),  32'h1);

        // ---------------- random program against reference model ----------------
        for (int i = 0; i < 256; i++) mem0[i] = 8'h00;
        pc_m = 0;
        n_illegal = 0;
        for (int k = 0; k < 30; k++) begin
            int op, len, stp, o1, o2;
            bit legal;
            if ($urandom_range(0, 4) == 0) op = int'($urandom_range('h11, 'hfe));
            else                           op = int'($urandom_range(0, 'h10));
            ref_lookup(op, len, stp, legal);
            o1 = (len >= 2) ? int'($urandom_range(0, 255)) : 0;
            o2 = (len == 3) ? int'($urandom_range(0, 255)) : 0;
            mem0[pc_m] = 8'(op);
            if (len >= 2) mem0[pc_m + 1] = 8'(o1);
            if (len == 3) mem0[pc_m + 2] = 8'(o2);
            pc_m += len;
            exp_op.push_back(op); exp_o1.push_back(o1); exp_o2.push_back(o2);
            exp_stp.push_back(stp); exp_end.push_back(pc_m);
            if (!legal) n_illegal++;
        end
        mem0[pc_m] = 8'hff;

        tick();
        reset0 = 1'b1;
        idx = 0;
        unstalled = 0;
        illegal_seen = 0;
        for (int cyc = 0; cyc < 3000 && idx < 30; cyc++) begin
            code_valid0 = ($urandom_range(0, 9) < 7);
            stall0      = ($urandom_range(0, 9) < 3);
            #1;
            if (illegal0) illegal_seen++;
            if (exec_valid0) begin
                chk("rnd_opcode",   32'(opcode0),    32'(exp_op[idx]));
                chk("rnd_operand1", 32'(operand1_0), 32'(exp_o1[idx]));
                chk("rnd_operand2", 32'(operand2_0), 32'(exp_o2[idx]));
                if (!stall0) unstalled++;
                if (instr_done0) begin
                    chk("rnd_step_count", 32'(unstalled),  32'(exp_stp[idx]));
                    chk("rnd_end_pc",     32'(code_addr0), 32'(exp_end[idx]));
                    idx++;
                    unstalled = 0;
                end
            end
            tick();
        end
        chk("rnd_all_retired", 32'(idx), 32'd30);

        code_valid0 = 1'b1;
        for (int w = 0; w < 50 && !halted0; w++) tick();
        chk("rnd_halted",        32'(halted0),      32'h1);
        chk("rnd_illegal_count", 32'(illegal_seen), 32'(n_illegal));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_instruction_sequencer
`default_nettype wire
